// File: rtl/note_i2s_player.sv
// Dual square-wave tone generator feeding a Philips I2S serializer (mclk/lrck/sck/sdin).
// Optional `VOLUME_EN selects amplitude from volume; otherwise amplitude is fixed at 16'h2000.
module note_i2s_player (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] note_div_left,
  input  logic [21:0] note_div_right,
  input  logic [2:0]  volume,
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin
);
  localparam int DATA_W = 16;
  localparam int DIV_W  = 22;

  logic [8:0]               cnt_q, cnt_d;
  logic [DIV_W-1:0]         tcnt_l_q, tcnt_l_d, tcnt_r_q, tcnt_r_d;
  logic                     lvl_l_q, lvl_l_d, lvl_r_q, lvl_r_d;
  logic [2*DATA_W-1:0]      frame_q, frame_d;
  logic                     sdin_q, sdin_d;
  logic signed [DATA_W-1:0] amp, samp_l, samp_r;

`ifdef VOLUME_EN
  // Codes above 4 clamp to the largest safe amplitude.
  function automatic logic signed [DATA_W-1:0] amp_sat(input logic [2:0] vol);
    case (vol)
      3'd0:    return 16'sh0000;
      3'd1:    return 16'sh0400;
      3'd2:    return 16'sh0800;
      3'd3:    return 16'sh1000;
      3'd4:    return 16'sh2000;
      default: return 16'sh4000;
    endcase
  endfunction

  assign amp = amp_sat(volume);
`else
  logic vol_unused;
  assign vol_unused = ^volume;
  assign amp        = 16'sh2000;
`endif

  // Returns {lvl_next, tcnt_next}; the >= compare absorbs a shrinking divider mid-count.
  function automatic logic [DIV_W:0] tone_next(input logic [DIV_W-1:0] div,
                                               input logic [DIV_W-1:0] tcnt,
                                               input logic             lvl);
    if (div == '0)
      return '0;
    else if (tcnt >= div - 1'b1)
      return {~lvl, {DIV_W{1'b0}}};
    else
      return {lvl, tcnt + 1'b1};
  endfunction

  function automatic logic signed [DATA_W-1:0] tone_sample(input logic [DIV_W-1:0]         div,
                                                          input logic                     lvl,
                                                          input logic signed [DATA_W-1:0] a);
    if (div == '0)
      return '0;
    else
      return lvl ? a : -a;
  endfunction

  assign samp_l = tone_sample(note_div_left,  lvl_l_q, amp);
  assign samp_r = tone_sample(note_div_right, lvl_r_q, amp);

  always_comb begin
    cnt_d                = cnt_q + 9'd1;
    {lvl_l_d, tcnt_l_d}  = tone_next(note_div_left,  tcnt_l_q, lvl_l_q);
    {lvl_r_d, tcnt_r_d}  = tone_next(note_div_right, tcnt_r_q, lvl_r_q);
    frame_d              = frame_q;
    sdin_d               = sdin_q;
    if (cnt_q == 9'd511)
      frame_d = {samp_l, samp_r};
    // Next slot s carries frame bit 32-s; at the wrap that index is 0 of the outgoing frame,
    // which is still in frame_q because capture happens on the same edge.
    if (cnt_q[3:0] == 4'hF)
      sdin_d = frame_q[~cnt_q[8:4]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      tcnt_l_q <= '0;
      tcnt_r_q <= '0;
      lvl_l_q  <= 1'b0;
      lvl_r_q  <= 1'b0;
      frame_q  <= '0;
      sdin_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tcnt_l_q <= tcnt_l_d;
      tcnt_r_q <= tcnt_r_d;
      lvl_l_q  <= lvl_l_d;
      lvl_r_q  <= lvl_r_d;
      frame_q  <= frame_d;
      sdin_q   <= sdin_d;
    end
  end

  assign audio_mclk = cnt_q[1];
  assign audio_sck  = cnt_q[3];
  assign audio_lrck = cnt_q[8];
  assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_note_i2s_player.sv
// Bench for note_i2s_player: random note/volume changes against a closed-form tone model,
// with the I2S stream decoded back into frames. Define VOLUME_EN to match a VOLUME_EN build.
module tb_note_i2s_player;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] note_div_left  = '0;
  logic [21:0] note_div_right = '0;
  logic [2:0]  volume = '0;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin;

  int checks   = 0;
  int failures = 0;

  note_i2s_player dut (
    .clk            (clk),
    .rst            (rst),
    .note_div_left  (note_div_left),
    .note_div_right (note_div_right),
    .volume         (volume),
    .audio_mclk     (audio_mclk),
    .audio_lrck     (audio_lrck),
    .audio_sck      (audio_sck),
    .audio_sdin     (audio_sdin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Tone model: lvl after e edges = lvl0 ^ parity(floor((e - anchor) / div)).
  longint      ecnt = 0;
  longint      div_m[2];
  longint      anc_m[2];
  bit          lvl0_m[2];
  logic [31:0] exp_q[$];
  int          decoded = 0;

  function automatic bit lvl_at(input int ch, input longint e);
    if (div_m[ch] == 0) return 1'b0;
    return lvl0_m[ch] ^ ((((e - anc_m[ch]) / div_m[ch]) % 2) != 0);
  endfunction

  function automatic logic [15:0] amp_now();
`ifdef VOLUME_EN
    case (volume)
      3'd0: return 16'h0000;
      3'd1: return 16'h0400;
      3'd2: return 16'h0800;
      3'd3: return 16'h1000;
      3'd4: return 16'h2000;
      default: return 16'h4000;
    endcase
`else
    return 16'h2000;
`endif
  endfunction

  function automatic logic [15:0] samp_of(input int ch);
    logic [15:0] a;
    a = amp_now();
    if (div_m[ch] == 0) return 16'h0000;
    return lvl_at(ch, ecnt) ? a : 16'h0000 - a;
  endfunction

  // Called between edges: re-anchors so the wave continues from its present level.
  task automatic set_div(input int ch, input longint nd);
    longint t;
    bit     cur;
    longint r;
    t   = ecnt;
    cur = lvl_at(ch, t);
    if (nd == 0) begin
      div_m[ch] = 0;
    end else if (div_m[ch] == 0) begin
      anc_m[ch]  = t;
      lvl0_m[ch] = 1'b0;
      div_m[ch]  = nd;
    end else begin
      r = (t - anc_m[ch]) % div_m[ch];
      if (r >= nd - 1) anc_m[ch] = t + 1 - nd;
      else             anc_m[ch] = t - r;
      lvl0_m[ch] = cur;
      div_m[ch]  = nd;
    end
    if (ch == 0) note_div_left = nd[21:0];
    else         note_div_right = nd[21:0];
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic release_rst();
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    for (int ch = 0; ch < 2; ch++) begin
      anc_m[ch]  = 0;
      lvl0_m[ch] = 1'b0;
    end
  endtask

  function automatic longint rand_div();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return $urandom_range(1, 2);
      2, 3:    return $urandom_range(3, 600);
      4:       return $urandom_range(600, 6000);
      default: return $urandom_range(6000, 200000);
    endcase
  endfunction

  // Expected frame captured on the wrap edge, from pre-edge state.
  always @(posedge clk) begin
    if (rst) begin
      ecnt <= 0;
    end else begin
      if ((ecnt + 1) % 512 == 0) exp_q.push_back({samp_of(0), samp_of(1)});
      ecnt <= ecnt + 1;
    end
  end

  // I2S decoder and clock-shape checks, sampled on the falling clk edge.
  logic        psck, plrck, pmclk, psdin, fell;
  logic [31:0] sh;
  longint      last_mclk, last_sck, last_lrck;

  always @(negedge clk) begin
    if (rst) begin
      psck <= 1'b0; plrck <= 1'b0; pmclk <= 1'b0; psdin <= 1'b0;
      fell <= 1'b0; sh <= '0;
      last_mclk <= -1; last_sck <= -1; last_lrck <= -1;
    end else begin
      if (audio_sdin !== psdin) chk("sdin_change_phase", ecnt % 16, 0);
      if (audio_mclk && !pmclk) begin
        if (last_mclk >= 0) chk("mclk_period", ecnt - last_mclk, 4);
        last_mclk <= ecnt;
      end
      if (audio_sck && !psck) begin
        if (last_sck >= 0) chk("sck_period", ecnt - last_sck, 16);
        last_sck <= ecnt;
        sh <= {sh[30:0], audio_sdin};
        if (fell) begin
          fell <= 1'b0;
          if (exp_q.size() == 0) chk("exp_queue_nonempty", 0, 1);
          else chk("frame", {sh[30:0], audio_sdin}, exp_q.pop_front());
          decoded <= decoded + 1;
        end
      end
      if (audio_lrck && !plrck) begin
        chk("lrck_rise_phase", ecnt % 512, 256);
        if (last_lrck >= 0) chk("lrck_period", ecnt - last_lrck, 512);
        last_lrck <= ecnt;
      end
      if (!audio_lrck && plrck) fell <= 1'b1;
      psck <= audio_sck; plrck <= audio_lrck; pmclk <= audio_mclk; psdin <= audio_sdin;
    end
  end

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      div_m[ch] = 0; anc_m[ch] = 0; lvl0_m[ch] = 1'b0;
    end
    step(10);
    chk("rst_mclk", audio_mclk, 0);
    chk("rst_sck",  audio_sck,  0);
    chk("rst_lrck", audio_lrck, 0);
    chk("rst_sdin", audio_sdin, 0);
    release_rst();

    // Rest: line stays silent.
    for (int i = 0; i < 128; i++) begin
      step(16);
      chk("rest_sdin", audio_sdin, 0);
    end

    // Single tone, left only.
    set_div(0, 1000);
    set_div(1, 0);
    step(6 * 512);

    // Mid-count decrease.
    set_div(0, 3000);
    step(2500);
    set_div(0, 700);
    step(4 * 512);

    // Random notes and volumes.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) set_div(0, rand_div());
      if ($urandom_range(0, 1) == 1) set_div(1, rand_div());
      volume = 3'($urandom_range(0, 7));
      step($urandom_range(1, 1500));
    end

    // Asynchronous reset mid-frame.
    step($urandom_range(20, 400));
    rst = 1'b1;
    #1;
    chk("midrst_mclk", audio_mclk, 0);
    chk("midrst_sck",  audio_sck,  0);
    chk("midrst_lrck", audio_lrck, 0);
    chk("midrst_sdin", audio_sdin, 0);
    step(3);
    set_div(0, 0);
    set_div(1, 0);
    set_div(0, 257);
    set_div(1, 1);
    volume = 3'd5;
    release_rst();
    step(4 * 512);
    set_div(1, 90);
    step(3 * 512);

    chk("frames_decoded_enough", (decoded > 50) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
